// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-buffered UART peripheral.
// Build option: define UART_PARITY_EN to include parity generation/checking.
package uart_pkg;

  // Register word indices
  localparam logic [5:0] REG_DATA   = 6'd0;
  localparam logic [5:0] REG_STATUS = 6'd1;
  localparam logic [5:0] REG_CTRL   = 6'd2;
  localparam logic [5:0] REG_BRR    = 6'd3;
  localparam logic [5:0] REG_IE     = 6'd4;
  localparam logic [5:0] REG_LEVEL  = 6'd5;

  // CTRL[3:2] parity modes (0x = none)
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_ODD  = 2'b11;

  // STATUS bit positions
  localparam int unsigned ST_RX_NE    = 0;
  localparam int unsigned ST_RX_FULL  = 1;
  localparam int unsigned ST_TX_EMPTY = 2;
  localparam int unsigned ST_TX_FULL  = 3;
  localparam int unsigned ST_FE       = 4;
  localparam int unsigned ST_PE       = 5;
  localparam int unsigned ST_OVR      = 6;
  localparam int unsigned ST_TX_IDLE  = 7;

  // IE bit positions
  localparam int unsigned IE_RX_NE    = 0;
  localparam int unsigned IE_TX_EMPTY = 1;
  localparam int unsigned IE_ERR      = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP1,
    TX_STOP2
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  // Parity bit that makes the frame even (odd=0) or odd (odd=1)
  function automatic logic parity_bit(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A pop on a full FIFO frees the slot for a same-cycle push.
module uart_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  // Storage array; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_periph.sv
// Memory-mapped UART with TX/RX FIFOs, programmable frame and level irq.
// Build option: UART_PARITY_EN enables CTRL[3:2] parity and STATUS pe.
module uart_fifo_periph
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BRR_WIDTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] data_out,
  input  logic [31:0] data_in,
  input  logic [5:0]  addr,
  input  logic        cs,
  input  logic        oe,
  input  logic [3:0]  wstrb,
  input  logic        rxd,
  output logic        txd,
  output logic        irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  // Bus decode
  logic        wr_en, rd_en, st_clr;
  logic [31:0] wmask;
  assign wr_en  = cs && (wstrb != '0) && !rst;
  assign rd_en  = cs && oe && !rst;
  assign st_clr = wr_en && (addr == REG_STATUS) && wstrb[0];
  assign wmask  = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};

  // Programmer-visible registers
  logic [4:0]           ctrl;
  logic [BRR_WIDTH-1:0] brr;
  logic [2:0]           ie;
  logic                 st_fe, st_pe, st_ovr;
  logic                 tx_wr_pend;
  logic [7:0]           tx_wr_byte;
  logic                 tx_en, rx_en;
  assign tx_en = ctrl[0];
  assign rx_en = ctrl[1];

  // FIFO interfaces
  logic          tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_rdata;
  logic [CW-1:0] tx_count;
  logic          rx_push, rx_pop, rx_full, rx_empty, rx_drop;
  logic [9:0]    rx_word, rx_rdata;
  logic [CW-1:0] rx_count;

  assign rx_pop  = rd_en && (addr == REG_DATA) && !rx_empty;
  assign rx_drop = rx_push && rx_full && !rx_pop;

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_wr_pend), .wdata(tx_wr_byte), .pop(tx_pop),
    .rdata(tx_rdata), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(10)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .wdata(rx_word), .pop(rx_pop),
    .rdata(rx_rdata), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  // Register writes, sticky error flags and DATA write staging
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl       <= '0;
      brr        <= '0;
      ie         <= '0;
      st_fe      <= 1'b0;
      st_pe      <= 1'b0;
      st_ovr     <= 1'b0;
      tx_wr_pend <= 1'b0;
      tx_wr_byte <= '0;
    end else begin
      tx_wr_pend <= wr_en && (addr == REG_DATA) && wstrb[0];
      tx_wr_byte <= data_in[7:0];
      if (wr_en && (addr == REG_CTRL) && wstrb[0]) begin
        ctrl[0] <= data_in[0];
        ctrl[1] <= data_in[1];
        ctrl[4] <= data_in[4];
`ifdef UART_PARITY_EN
        ctrl[3:2] <= data_in[3:2];
`endif
      end
      if (wr_en && (addr == REG_BRR))
        brr <= (brr & ~wmask[BRR_WIDTH-1:0]) | (data_in[BRR_WIDTH-1:0] & wmask[BRR_WIDTH-1:0]);
      if (wr_en && (addr == REG_IE) && wstrb[0]) ie <= data_in[2:0];
      // A new error in the same cycle as a clear wins
      st_fe  <= (st_fe  && !(st_clr && data_in[ST_FE]))  || (rx_push && rx_word[8]);
      st_pe  <= (st_pe  && !(st_clr && data_in[ST_PE]))  || (rx_push && rx_word[9]);
      st_ovr <= (st_ovr && !(st_clr && data_in[ST_OVR])) || rx_drop;
    end
  end

  // ---------------- Transmitter ----------------
  tx_state_t            tx_st;
  logic [BRR_WIDTH-1:0] tx_cnt, tx_brr;
  logic [2:0]           tx_bit;
  logic [7:0]           tx_byte;
  logic                 tx_two_stop, tx_last, tx_idle;
`ifdef UART_PARITY_EN
  logic                 tx_par_en, tx_par_odd;
`endif

  assign tx_idle = (tx_st == TX_IDLE);
  // Final stop bit expiring: a queued byte starts its frame without an idle gap
  assign tx_last = (tx_cnt == '0) &&
                   ((tx_st == TX_STOP2) || ((tx_st == TX_STOP1) && !tx_two_stop));
  assign tx_pop  = tx_en && !tx_empty && (tx_idle || tx_last);

  // TX frame sequencer; frame format and divisor latched at frame start
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st       <= TX_IDLE;
      txd         <= 1'b1;
      tx_cnt      <= '0;
      tx_brr      <= '0;
      tx_bit      <= '0;
      tx_byte     <= '0;
      tx_two_stop <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_en   <= 1'b0;
      tx_par_odd  <= 1'b0;
`endif
    end else if (tx_pop) begin
      tx_st       <= TX_START;
      txd         <= 1'b0;
      tx_byte     <= tx_rdata;
      tx_brr      <= brr;
      tx_cnt      <= brr;
      tx_two_stop <= ctrl[4];
`ifdef UART_PARITY_EN
      tx_par_en   <= ctrl[3];
      tx_par_odd  <= ctrl[2];
`endif
    end else begin
      if (!tx_idle) tx_cnt <= (tx_cnt == '0) ? tx_brr : tx_cnt - 1'b1;
      case (tx_st)
        TX_IDLE: txd <= 1'b1;
        TX_START:
          if (tx_cnt == '0) begin
            tx_st  <= TX_DATA;
            txd    <= tx_byte[0];
            tx_bit <= '0;
          end
        TX_DATA:
          if (tx_cnt == '0) begin
            if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              if (tx_par_en) begin
                tx_st <= TX_PARITY;
                txd   <= parity_bit(tx_byte, tx_par_odd);
              end else begin
                tx_st <= TX_STOP1;
                txd   <= 1'b1;
              end
`else
              tx_st <= TX_STOP1;
              txd   <= 1'b1;
`endif
            end else begin
              tx_bit <= tx_bit + 3'd1;
              txd    <= tx_byte[tx_bit + 3'd1];
            end
          end
`ifdef UART_PARITY_EN
        TX_PARITY:
          if (tx_cnt == '0) begin
            tx_st <= TX_STOP1;
            txd   <= 1'b1;
          end
`endif
        TX_STOP1:
          if (tx_cnt == '0) tx_st <= tx_two_stop ? TX_STOP2 : TX_IDLE;
        TX_STOP2:
          if (tx_cnt == '0) tx_st <= TX_IDLE;
        default: tx_st <= TX_IDLE;
      endcase
    end
  end

  // ---------------- Receiver ----------------
  rx_state_t            rx_st;
  logic                 rx_s1, rx_s2, rx_s3;
  logic [BRR_WIDTH-1:0] rx_cnt, rx_brr;
  logic [2:0]           rx_bit;
  logic [7:0]           rx_sh;
  logic                 rx_pe;
`ifdef UART_PARITY_EN
  logic                 rx_par_en, rx_par_odd, rx_par_bit;
  assign rx_pe = rx_par_en && (rx_par_bit != parity_bit(rx_sh, rx_par_odd));
`else
  assign rx_pe = 1'b0;
`endif

  // Input synchroniser plus one extra stage for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // RX frame sequencer with mid-bit sampling and registered FIFO push
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st   <= RX_IDLE;
      rx_cnt  <= '0;
      rx_brr  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
      rx_push <= 1'b0;
      rx_word <= '0;
`ifdef UART_PARITY_EN
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
      rx_par_bit <= 1'b0;
`endif
    end else begin
      rx_push <= 1'b0;
      if (rx_st != RX_IDLE) rx_cnt <= (rx_cnt == '0) ? rx_brr : rx_cnt - 1'b1;
      if (!rx_en) begin
        rx_st <= RX_IDLE;
      end else begin
        case (rx_st)
          RX_IDLE:
            if (rx_s3 && !rx_s2) begin
              rx_st  <= RX_START;
              rx_brr <= brr;
              rx_cnt <= brr >> 1;
`ifdef UART_PARITY_EN
              rx_par_en  <= ctrl[3];
              rx_par_odd <= ctrl[2];
`endif
            end
          RX_START:
            if (rx_cnt == '0) begin
              if (rx_s2) begin
                rx_st <= RX_IDLE;
              end else begin
                rx_st  <= RX_DATA;
                rx_bit <= '0;
              end
            end
          RX_DATA:
            if (rx_cnt == '0) begin
              rx_sh  <= {rx_s2, rx_sh[7:1]};
              rx_bit <= rx_bit + 3'd1;
              if (rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                rx_st <= rx_par_en ? RX_PARITY : RX_STOP;
`else
                rx_st <= RX_STOP;
`endif
              end
            end
`ifdef UART_PARITY_EN
          RX_PARITY:
            if (rx_cnt == '0) begin
              rx_par_bit <= rx_s2;
              rx_st      <= RX_STOP;
            end
`endif
          RX_STOP:
            if (rx_cnt == '0) begin
              rx_push <= 1'b1;
              rx_word <= {rx_pe, !rx_s2, rx_sh};
              rx_st   <= RX_IDLE;
            end
          default: rx_st <= RX_IDLE;
        endcase
      end
    end
  end

  // ---------------- Read mux and interrupt ----------------
  logic [7:0] status;
  assign status = {tx_idle, st_ovr, st_pe, st_fe, tx_full, tx_empty, rx_full, !rx_empty};

  assign irq = !rst && |(ie & {st_fe | st_pe | st_ovr, tx_empty && tx_idle, !rx_empty});

  // Combinational read data, zero outside a read access
  always_comb begin
    data_out = '0;
    if (rd_en) begin
      case (addr)
        REG_DATA:   if (!rx_empty) data_out[9:0] = rx_rdata;
        REG_STATUS: data_out[7:0] = status;
        REG_CTRL:   data_out[4:0] = ctrl;
        REG_BRR:    data_out[BRR_WIDTH-1:0] = brr;
        REG_IE:     data_out[2:0] = ie;
        REG_LEVEL: begin
          data_out[CW-1:0]    = rx_count;
          data_out[16 +: CW]  = tx_count;
        end
        default: ;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{data_in, wmask};

endmodule

// File: tb/tb_uart_fifo_periph.sv
// Self-checking bench for uart_fifo_periph: random bytes through TX and RX
// checked against queue-based frame models.
module tb_uart_fifo_periph;
  import uart_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_out, data_in;
  logic [5:0]  addr;
  logic        cs, oe;
  logic [3:0]  wstrb;
  logic        rxd, txd, irq;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned bitp  = 4;
  logic [9:0]  rxq[$];
  logic [7:0]  txq[$];

  uart_fifo_periph #(.FIFO_DEPTH(DEPTH), .BRR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .data_out(data_out), .data_in(data_in), .addr(addr),
    .cs(cs), .oe(oe), .wstrb(wstrb), .rxd(rxd), .txd(txd), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns two negedges later so the write has landed
  task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    cs = 1'b1; oe = 1'b0; addr = a; data_in = d; wstrb = s;
    @(negedge clk);
    cs = 1'b0; wstrb = '0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    cs = 1'b1; oe = 1'b1; addr = a; wstrb = '0;
    #1 d = data_out;
    @(negedge clk);
    cs = 1'b0; oe = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [5:0] a, input logic [31:0] mask,
                            input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d & mask, exp);
  endtask

  // Drive one serial frame on rxd, then two bit times of idle line
  task automatic rx_send(input logic [7:0] b, input bit stop_hi, input bit par_on,
                         input bit par_odd, input bit par_bad);
    rxd = 1'b0;
    repeat (bitp) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (bitp) @(negedge clk);
    end
    if (par_on) begin
      rxd = (^b) ^ par_odd ^ par_bad;
      repeat (bitp) @(negedge clk);
    end
    rxd = stop_hi;
    repeat (bitp) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * bitp) @(negedge clk);
  endtask

  // Reference RX FIFO: push or drop, reporting overflow
  task automatic model_rx(input logic [9:0] w, inout bit ovr);
    if (rxq.size() < DEPTH) rxq.push_back(w);
    else ovr = 1'b1;
  endtask

  // Decode one frame from txd by sampling at bit centres
  task automatic tx_get(input int unsigned nstop, output logic [7:0] b);
    int unsigned w = 0;
    b = '0;
    while (txd && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("tx_start_seen", 64'(w < 2000), 64'd1);
    repeat (bitp / 2) @(negedge clk);
    check("tx_start_mid", 64'(txd), 64'd0);
    for (int k = 0; k < 8; k++) begin
      repeat (bitp) @(negedge clk);
      b[k] = txd;
    end
    for (int unsigned s = 0; s < nstop; s++) begin
      repeat (bitp) @(negedge clk);
      check("tx_stop", 64'(txd), 64'd1);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [39:0] wave, expw;
    logic [7:0]  b, got;
    int unsigned lat;
    bit          ovr_m;

    cs = 0; oe = 0; wstrb = '0; addr = '0; data_in = '0; rxd = 1'b1; rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd", 64'(txd), 64'd1);
    check("rst_irq", 64'(irq), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset register values
    read_check("rst_status", REG_STATUS, 32'hFFFF_FFFF, 32'h84);
    read_check("rst_ctrl",   REG_CTRL,   32'hFFFF_FFFF, 32'h0);
    read_check("rst_brr",    REG_BRR,    32'hFFFF_FFFF, 32'h0);
    read_check("rst_ie",     REG_IE,     32'hFFFF_FFFF, 32'h0);
    read_check("rst_level",  REG_LEVEL,  32'hFFFF_FFFF, 32'h0);
    read_check("rst_data",   REG_DATA,   32'hFFFF_FFFF, 32'h0);

    // Byte-lane BRR writes
    bus_write(REG_BRR, 32'h0000_0003, 4'b0011);
    bus_write(REG_BRR, 32'hFFFF_ABCD, 4'b0010);
    read_check("brr_lane", REG_BRR, 32'hFFFF_FFFF, 32'h0000_AB03);
    bus_write(REG_BRR, 32'h0000_0003, 4'b0011);
    bus_write(REG_CTRL, 32'h1F, 4'b0001);
`ifdef UART_PARITY_EN
    read_check("ctrl_rb", REG_CTRL, 32'hFFFF_FFFF, 32'h1F);
`else
    read_check("ctrl_rb", REG_CTRL, 32'hFFFF_FFFF, 32'h13);
`endif

    // A: single 8N1 frame 0x55 at BRR=3
    bus_write(REG_CTRL, 32'h01, 4'b0001);
    bus_write(REG_DATA, 32'h55, 4'b0001);
    lat = 0;
    while (txd && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("tx_latency", 64'(lat), 64'd1);
    b = 8'h55;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      wave[i] = txd;
      expw[i] = (i < 4) ? 1'b0 : (i < 36) ? b[(i - 4) / 4] : 1'b1;
    end
    check("tx_wave_55", 64'(wave), 64'(expw));
    read_check("tx_busy_39", REG_STATUS, 32'h80, 32'h00);
    read_check("tx_idle_40", REG_STATUS, 32'h80, 32'h80);

    // B: fill TX FIFO while disabled, then drain back to back
    bus_write(REG_CTRL, 32'h00, 4'b0001);
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      if (txq.size() < DEPTH) txq.push_back(b);
      bus_write(REG_DATA, {24'h0, b}, 4'b0001);
    end
    read_check("tx_level_full", REG_LEVEL, 32'hFFFF_FFFF, 32'(DEPTH) << 16);
    read_check("tx_full_flag", REG_STATUS, 32'h0C, 32'h08);
    bus_write(REG_IE, 32'h2, 4'b0001);
    check("irq_tx_busy", 64'(irq), 64'd0);
    bus_write(REG_CTRL, 32'h01, 4'b0001);
    while (txq.size() > 0) begin
      tx_get(1, got);
      check("tx_byte", 64'(got), 64'(txq.pop_front()));
    end
    lat = 0;
    while (!irq && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("irq_tx_empty", 64'(irq), 64'd1);

    // Two stop bits at BRR=5
    bus_write(REG_IE, 32'h0, 4'b0001);
    bus_write(REG_BRR, 32'h5, 4'b0011);
    bitp = 6;
    bus_write(REG_CTRL, 32'h10, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      txq.push_back(b);
      bus_write(REG_DATA, {24'h0, b}, 4'b0001);
    end
    bus_write(REG_CTRL, 32'h11, 4'b0001);
    while (txq.size() > 0) begin
      tx_get(2, got);
      check("tx_byte_2stop", 64'(got), 64'(txq.pop_front()));
    end
    repeat (20) @(negedge clk);

    // C: receive random bytes
    bus_write(REG_BRR, 32'h3, 4'b0011);
    bitp = 4;
    bus_write(REG_CTRL, 32'h02, 4'b0001);
    bus_write(REG_IE, 32'h1, 4'b0001);
    check("irq_rx_empty", 64'(irq), 64'd0);
    ovr_m = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      rx_send(b, 1'b1, 1'b0, 1'b0, 1'b0);
      model_rx({2'b00, b}, ovr_m);
    end
    check("irq_rx_ne", 64'(irq), 64'd1);
    read_check("rx_level", REG_LEVEL, 32'hFFFF_FFFF, 32'(rxq.size()));
    while (rxq.size() > 0) read_check("rx_data", REG_DATA, 32'hFFFF_FFFF, 32'(rxq.pop_front()));
    read_check("rx_empty_read", REG_DATA, 32'hFFFF_FFFF, 32'h0);
    read_check("rx_status_empty", REG_STATUS, 32'h73, 32'h0);

    // D: framing error, sticky clear, glitch rejection
    b = 8'($urandom);
    rx_send(b, 1'b0, 1'b0, 1'b0, 1'b0);
    model_rx({2'b01, b}, ovr_m);
    read_check("fe_sticky", REG_STATUS, 32'h70, 32'h10);
    bus_write(REG_IE, 32'h4, 4'b0001);
    check("irq_err", 64'(irq), 64'd1);
    read_check("fe_entry", REG_DATA, 32'hFFFF_FFFF, 32'(rxq.pop_front()));
    bus_write(REG_STATUS, 32'h10, 4'b0001);
    read_check("fe_cleared", REG_STATUS, 32'h70, 32'h00);
    check("irq_err_clr", 64'(irq), 64'd0);
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    read_check("glitch_level", REG_LEVEL, 32'hFFFF_FFFF, 32'h0);

`ifdef UART_PARITY_EN
    // Even parity: correct then corrupted parity bit
    bus_write(REG_CTRL, 32'h0A, 4'b0001);
    rx_send(8'hA3, 1'b1, 1'b1, 1'b0, 1'b0);
    rx_send(8'hA3, 1'b1, 1'b1, 1'b0, 1'b1);
    read_check("par_ok",  REG_DATA, 32'hFFFF_FFFF, 32'h0A3);
    read_check("par_bad", REG_DATA, 32'hFFFF_FFFF, 32'h2A3);
    read_check("pe_sticky", REG_STATUS, 32'h70, 32'h20);
    check("irq_pe", 64'(irq), 64'd1);
    bus_write(REG_STATUS, 32'h20, 4'b0001);
    read_check("pe_cleared", REG_STATUS, 32'h70, 32'h00);
    bus_write(REG_CTRL, 32'h02, 4'b0001);
`endif

    // E: overflow with DEPTH+1 frames
    for (int unsigned i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      rx_send(b, 1'b1, 1'b0, 1'b0, 1'b0);
      model_rx({2'b00, b}, ovr_m);
    end
    read_check("ovr_status", REG_STATUS, 32'h43, {25'h0, ovr_m, 6'h03});
    check("irq_ovr", 64'(irq), 64'd1);
    while (rxq.size() > 0) read_check("ovr_data", REG_DATA, 32'hFFFF_FFFF, 32'(rxq.pop_front()));
    read_check("ovr_drained", REG_DATA, 32'hFFFF_FFFF, 32'h0);
    bus_write(REG_STATUS, 32'h40, 4'b0001);
    read_check("ovr_cleared", REG_STATUS, 32'h70, 32'h00);

    // G: reset in the middle of a TX frame with a pending rx irq
    bus_write(REG_CTRL, 32'h03, 4'b0001);
    bus_write(REG_IE, 32'h1, 4'b0001);
    rx_send(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    check("irq_pre_rst", 64'(irq), 64'd1);
    bus_write(REG_DATA, 32'h00, 4'b0001);
    lat = 0;
    while (txd && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("tx_pre_rst_low", 64'(txd), 64'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1; cs = 1'b1; oe = 1'b1; addr = REG_STATUS;
    #1 check("rst_data_out", 64'(data_out), 64'd0);
    @(negedge clk);
    check("rst_mid_txd", 64'(txd), 64'd1);
    check("rst_mid_irq", 64'(irq), 64'd0);
    cs = 1'b0; oe = 1'b0; rst = 1'b0;
    @(negedge clk);
    read_check("post_status", REG_STATUS, 32'hFFFF_FFFF, 32'h84);
    read_check("post_ctrl",   REG_CTRL,   32'hFFFF_FFFF, 32'h0);
    read_check("post_brr",    REG_BRR,    32'hFFFF_FFFF, 32'h0);
    read_check("post_ie",     REG_IE,     32'hFFFF_FFFF, 32'h0);
    read_check("post_level",  REG_LEVEL,  32'hFFFF_FFFF, 32'h0);
    repeat (10) @(negedge clk);
    check("post_txd", 64'(txd), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
